// File: rtl/idelay_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : idelay_tap_ctrl
// Purpose  : Tap sequencer for a bank of IDELAYE2 primitives in VARIABLE
//            mode. Accepts SET / INC / DEC / LOAD commands over a valid/ready
//            handshake and turns each one into spaced single-cycle CE/INC/LD
//            pulses on the addressed channel. It keeps a per-channel tap model
//            so callers can ask for absolute tap targets.
// Ports    : clk, rst (async, active high), rdy (IDELAYCTRL RDY)
//            req_valid/req_ready/req_cmd/req_chan/req_tap : command handshake
//            ce/inc/ld  : per-channel IDELAYE2 controls
//            tap_out    : packed tap model, channel k at [5k+4:5k]
//            busy/done/err : status (done and err are one-cycle pulses)
// Revision : 1.0 - initial release
// ============================================================================
module idelay_tap_ctrl #(
    parameter int CHANNELS  = 4,
    parameter int CHAN_BITS = 2,
    parameter int INIT_TAP  = 0,
    parameter int STEP_GAP  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_cmd,
    input  logic [CHAN_BITS-1:0]    req_chan,
    input  logic [4:0]              req_tap,
    output logic [CHANNELS-1:0]     ce,
    output logic [CHANNELS-1:0]     inc,
    output logic [CHANNELS-1:0]     ld,
    output logic [5*CHANNELS-1:0]   tap_out,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_GAP  = 3'd1;
    localparam logic [2:0] S_STEP = 3'd2;
    localparam logic [2:0] S_LOAD = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [1:0] CMD_SET  = 2'b00;
    localparam logic [1:0] CMD_INC  = 2'b01;
    localparam logic [1:0] CMD_DEC  = 2'b10;

    localparam logic [4:0]           C_INIT   = INIT_TAP[4:0];
    localparam logic [CHAN_BITS:0]   C_NCHAN  = (CHAN_BITS+1)'(CHANNELS);
    localparam int                   GAP_W    = (STEP_GAP > 2) ? $clog2(STEP_GAP) : 1;
    // A GAP visit lasts (reload + 1) cycles while rdy is high, so STEP_GAP-2
    // gives STEP_GAP cycles from one STEP to the next.
    localparam logic [GAP_W-1:0]     C_GAP_LD = GAP_W'((STEP_GAP >= 2) ? (STEP_GAP - 2) : 0);

    logic [2:0]             r_state;
    logic [2:0]             w_next_state;

    logic [CHAN_BITS-1:0]   r_chan;
    logic                   r_dir;
    logic                   r_is_load;
    logic [4:0]             r_remain;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [4:0]             r_tap [CHANNELS];

    logic                   r_req_ready;
    logic [CHANNELS-1:0]    r_ce;
    logic [CHANNELS-1:0]    r_inc;
    logic [CHANNELS-1:0]    r_ld;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_chan_ok;
    logic [4:0]             w_cur;
    logic [4:0]             w_delta;
    logic [4:0]             w_plan_n;
    logic                   w_plan_dir;
    logic                   w_plan_load;
    logic [CHANNELS-1:0]    w_sel;

    logic                   w_req_ready_nxt;
    logic [CHANNELS-1:0]    w_ce_nxt;
    logic [CHANNELS-1:0]    w_inc_nxt;
    logic [CHANNELS-1:0]    w_ld_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;
    logic                   w_err_nxt;

    assign w_accept  = req_valid && r_req_ready && (r_state == S_IDLE);
    assign w_chan_ok = ({1'b0, req_chan} < C_NCHAN);

    // Current tap of the requested channel; out-of-range channels read INIT
    // but are never acted upon.
    always_comb begin
        w_cur = C_INIT;
        for (int k = 0; k < CHANNELS; k++) begin
            if (req_chan == CHAN_BITS'(k)) begin
                w_cur = r_tap[k];
            end
        end
    end

    // Step plan: shortest path around the 32-tap ring, ties go upward.
    always_comb begin
        w_delta     = req_tap - w_cur;
        w_plan_n    = 5'd0;
        w_plan_dir  = 1'b1;
        w_plan_load = 1'b0;
        case (req_cmd)
            CMD_SET: begin
                if (w_delta <= 5'd16) begin
                    w_plan_n = w_delta;
                end else begin
                    w_plan_n   = 5'd0 - w_delta;
                    w_plan_dir = 1'b0;
                end
            end
            CMD_INC: w_plan_n = 5'd1;
            CMD_DEC: begin
                w_plan_n   = 5'd1;
                w_plan_dir = 1'b0;
            end
            default: w_plan_load = 1'b1;
        endcase
    end

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_sel[k] = (r_chan == CHAN_BITS'(k));
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // GAP doubles as the settle cycle after acceptance and as the pause
    // state while rdy is low; the STEP and LOAD states coincide with the
    // cycles in which their pulses are visible on the outputs.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_chan_ok) begin
                    w_next_state = S_GAP;
                end
            end
            S_GAP: begin
                if (rdy && (r_gap_cnt == '0)) begin
                    if (r_is_load) begin
                        w_next_state = S_LOAD;
                    end else if (r_remain == 5'd0) begin
                        w_next_state = S_FIN;
                    end else begin
                        w_next_state = S_STEP;
                    end
                end
            end
            S_STEP: begin
                if (r_remain == 5'd0) begin
                    w_next_state = S_FIN;
                end else if ((STEP_GAP == 1) && rdy) begin
                    w_next_state = S_STEP;
                end else begin
                    w_next_state = S_GAP;
                end
            end
            S_LOAD:  w_next_state = S_FIN;
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output values for the next cycle, derived from the next state so the
    // registered outputs line up with the state they belong to.
    always_comb begin
        w_ce_nxt        = (w_next_state == S_STEP) ? w_sel : '0;
        w_inc_nxt       = w_ce_nxt & {CHANNELS{r_dir}};
        w_ld_nxt        = (w_next_state == S_LOAD) ? w_sel : '0;
        w_busy_nxt      = (w_next_state != S_IDLE);
        w_done_nxt      = (w_next_state == S_FIN);
        w_err_nxt       = w_accept && !w_chan_ok;
        w_req_ready_nxt = (w_next_state == S_IDLE) && rdy && !w_accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_ready <= 1'b0;
            r_ce        <= '0;
            r_inc       <= '0;
            r_ld        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_req_ready <= w_req_ready_nxt;
            r_ce        <= w_ce_nxt;
            r_inc       <= w_inc_nxt;
            r_ld        <= w_ld_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chan    <= '0;
            r_dir     <= 1'b0;
            r_is_load <= 1'b0;
            r_remain  <= 5'd0;
            r_gap_cnt <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_tap[k] <= C_INIT;
            end
        end else begin
            if (w_accept && w_chan_ok) begin
                r_chan    <= req_chan;
                r_dir     <= w_plan_dir;
                r_is_load <= w_plan_load;
                r_remain  <= w_plan_n;
                r_gap_cnt <= '0;
            end

            if ((r_state == S_STEP) && (w_next_state == S_GAP)) begin
                r_gap_cnt <= C_GAP_LD;
            end else if ((r_state == S_GAP) && rdy && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end

            if (w_next_state == S_STEP) begin
                r_remain <= r_remain - 5'd1;
            end

            // The model moves on the same edge that registers the pulse,
            // wrapping mod 32 like the IDELAYE2 tap counter.
            for (int k = 0; k < CHANNELS; k++) begin
                if (w_sel[k]) begin
                    if (w_next_state == S_STEP) begin
                        r_tap[k] <= r_dir ? (r_tap[k] + 5'd1) : (r_tap[k] - 5'd1);
                    end else if (w_next_state == S_LOAD) begin
                        r_tap[k] <= C_INIT;
                    end
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_tap_out
            assign tap_out[5*g +: 5] = r_tap[g];
        end
    endgenerate

    assign req_ready = r_req_ready;
    assign ce        = r_ce;
    assign inc       = r_inc;
    assign ld        = r_ld;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_idelay_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_idelay_tap_ctrl
// Purpose  : Directed self-checking bench for idelay_tap_ctrl. A 4-channel
//            instance covers stepping, wrap, shortest path, LOAD, rdy pause
//            and reset; a 3-channel instance covers the out-of-range channel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idelay_tap_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        valid4;
    logic        valid3;
    logic [1:0]  req_cmd;
    logic [1:0]  req_chan;
    logic [4:0]  req_tap;

    logic        ready4, busy4, done4, err4;
    logic [3:0]  ce4, inc4, ld4;
    logic [19:0] tap4;

    logic        ready3, busy3, done3, err3;
    logic [2:0]  ce3, inc3, ld3;
    logic [14:0] tap3;

    idelay_tap_ctrl #(.CHANNELS(4), .CHAN_BITS(2), .INIT_TAP(0), .STEP_GAP(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .req_valid(valid4), .req_ready(ready4),
        .req_cmd(req_cmd), .req_chan(req_chan), .req_tap(req_tap),
        .ce(ce4), .inc(inc4), .ld(ld4), .tap_out(tap4),
        .busy(busy4), .done(done4), .err(err4)
    );

    idelay_tap_ctrl #(.CHANNELS(3), .CHAN_BITS(2), .INIT_TAP(0), .STEP_GAP(2)) dut3 (
        .clk(clk), .rst(rst), .rdy(rdy),
        .req_valid(valid3), .req_ready(ready3),
        .req_cmd(req_cmd), .req_chan(req_chan), .req_tap(req_tap),
        .ce(ce3), .inc(inc3), .ld(ld3), .tap_out(tap3),
        .busy(busy3), .done(done3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor mux so one watcher serves either instance.
    logic       mon3;
    logic [3:0] m_ce, m_inc, m_ld;
    logic       m_done, m_busy, m_err, m_ready;
    assign m_ce    = mon3 ? {1'b0, ce3}  : ce4;
    assign m_inc   = mon3 ? {1'b0, inc3} : inc4;
    assign m_ld    = mon3 ? {1'b0, ld3}  : ld4;
    assign m_done  = mon3 ? done3  : done4;
    assign m_busy  = mon3 ? busy3  : busy4;
    assign m_err   = mon3 ? err3   : err4;
    assign m_ready = mon3 ? ready3 : ready4;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-cycle traces, bit c = cycle c after the accepting edge.
    logic [63:0] ce_m, inc_m, ld_m, done_m, busy_m, err_m, rdy_m;
    logic [63:0] any_ce_m, any_ld_m;
    logic        oth_ce, bad_inc;

    localparam logic [1:0] SET = 2'b00, INC = 2'b01, DEC = 2'b10, LOAD = 2'b11;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a command and hold it until the accepting edge; returns
    // #1 into cycle 0.
    task automatic issue(input bit use3, input logic [1:0] cmd,
                         input logic [1:0] chan, input logic [4:0] tap);
        int w;
        mon3     = use3;
        req_cmd  = cmd;
        req_chan = chan;
        req_tap  = tap;
        if (use3) valid3 = 1'b1; else valid4 = 1'b1;
        w = 0;
        while (!m_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("accept_ready", {63'd0, m_ready}, 64'd1);
        @(posedge clk); #1;
        valid3 = 1'b0;
        valid4 = 1'b0;
    endtask

    // Trace outputs from cycle 0 until two cycles past done or max_c cycles;
    // rdy is held low for cycles lo_s .. lo_s+lo_n-1.
    task automatic watch(input logic [1:0] chan, input int max_c,
                         input int lo_s, input int lo_n);
        int done_at;
        ce_m = '0; inc_m = '0; ld_m = '0; done_m = '0; busy_m = '0;
        err_m = '0; rdy_m = '0; any_ce_m = '0; any_ld_m = '0;
        oth_ce = 1'b0; bad_inc = 1'b0;
        done_at = -1;
        for (int c = 0; c < max_c; c++) begin
            ce_m[c]     = m_ce[chan];
            inc_m[c]    = m_inc[chan];
            ld_m[c]     = m_ld[chan];
            done_m[c]   = m_done;
            busy_m[c]   = m_busy;
            err_m[c]    = m_err;
            rdy_m[c]    = m_ready;
            any_ce_m[c] = |m_ce;
            any_ld_m[c] = |m_ld;
            if ((m_ce & ~(4'b0001 << chan)) != 4'b0000) oth_ce = 1'b1;
            if ((m_inc & ~m_ce) != 4'b0000) bad_inc = 1'b1;
            if (m_done && done_at < 0) done_at = c;
            if (done_at >= 0 && c >= done_at + 2) break;
            rdy = !(c >= lo_s && c < lo_s + lo_n);
            @(posedge clk); #1;
        end
        rdy = 1'b1;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; valid4 = 1'b0; valid3 = 1'b0; mon3 = 1'b0;
        req_cmd = 2'b00; req_chan = 2'b00; req_tap = 5'd0;

        // Reset state
        #12;
        chk("rst_ce",    {60'd0, ce4}, 64'd0);
        chk("rst_ready", {63'd0, ready4}, 64'd0);
        chk("rst_tap",   {44'd0, tap4}, 64'd0);
        chk("rst_flags", {53'd0, busy4, done4, err4, ld4, inc4}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", {63'd0, ready4}, 64'd1);

        // SET ch1 -> 5: five INC pulses at odd cycles, done at 10
        issue(0, SET, 2'd1, 5'd5);
        watch(2'd1, 64, 100, 0);
        chk("t1_ce",    ce_m,   64'h2AA);
        chk("t1_inc",   inc_m,  64'h2AA);
        chk("t1_done",  done_m, 64'h400);
        chk("t1_busy",  busy_m, 64'h7FF);
        chk("t1_other", {62'd0, oth_ce, bad_inc}, 64'd0);
        chk("t1_ready", {62'd0, rdy_m[11:10]}, 64'd2);
        chk("t1_tap",   {44'd0, tap4}, 64'h000A0);

        // ch0 to 2, then SET 30: four DEC pulses through the wrap
        issue(0, SET, 2'd0, 5'd2);
        watch(2'd0, 64, 100, 0);
        chk("t2_tap2", {44'd0, tap4}, 64'h000A2);
        issue(0, SET, 2'd0, 5'd30);
        watch(2'd0, 64, 100, 0);
        chk("t2_ce",   ce_m,   64'hAA);
        chk("t2_inc",  inc_m,  64'h0);
        chk("t2_done", done_m, 64'h100);
        chk("t2_tap",  {44'd0, tap4}, 64'h000BE);

        // ch0 to 31, then INC wraps to 0
        issue(0, SET, 2'd0, 5'd31);
        watch(2'd0, 64, 100, 0);
        issue(0, INC, 2'd0, 5'd0);
        watch(2'd0, 64, 100, 0);
        chk("t3_ce",   ce_m,   64'h2);
        chk("t3_inc",  inc_m,  64'h2);
        chk("t3_done", done_m, 64'h4);
        chk("t3_tap",  {44'd0, tap4}, 64'h000A0);

        // Delta exactly 16 steps upward
        issue(0, SET, 2'd0, 5'd16);
        watch(2'd0, 64, 100, 0);
        chk("t4_ce",   ce_m,   64'hAAAA_AAAA);
        chk("t4_inc",  inc_m,  64'hAAAA_AAAA);
        chk("t4_done", done_m, 64'h1_0000_0000);
        chk("t4_tap",  {44'd0, tap4}, 64'h000B0);

        // SET to the current value: no pulses, done at cycle 1
        issue(0, SET, 2'd1, 5'd5);
        watch(2'd1, 64, 100, 0);
        chk("t5_ce",   any_ce_m, 64'h0);
        chk("t5_done", done_m,   64'h2);
        chk("t5_busy", busy_m,   64'h3);

        // ch3 to 12, then LOAD
        issue(0, SET, 2'd3, 5'd12);
        watch(2'd3, 64, 100, 0);
        chk("t6_tap12", {44'd0, tap4}, 64'h600B0);
        issue(0, LOAD, 2'd3, 5'd0);
        watch(2'd3, 64, 100, 0);
        chk("t6_ld",   ld_m,     64'h2);
        chk("t6_ldall", any_ld_m, 64'h2);
        chk("t6_ce",   any_ce_m, 64'h0);
        chk("t6_done", done_m,   64'h4);
        chk("t6_tap",  {44'd0, tap4}, 64'h000B0);

        // 4-step SET on ch2 with rdy low during cycles 2..6
        issue(0, SET, 2'd2, 5'd4);
        watch(2'd2, 64, 2, 5);
        chk("t7_ce",   ce_m,   64'h1502);
        chk("t7_inc",  inc_m,  64'h1502);
        chk("t7_done", done_m, 64'h2000);
        chk("t7_tap",  {44'd0, tap4}, 64'h010B0);

        // DEC wraps ch3 from 0 to 31
        issue(0, DEC, 2'd3, 5'd0);
        watch(2'd3, 64, 100, 0);
        chk("t8_ce",  ce_m,  64'h2);
        chk("t8_inc", inc_m, 64'h0);
        chk("t8_tap", {44'd0, tap4}, 64'hF90B0);

        // Out-of-range channel on the 3-channel instance
        issue(1, SET, 2'd3, 5'd5);
        watch(2'd3, 6, 100, 0);
        chk("t9_err",  err_m,    64'h1);
        chk("t9_ce",   any_ce_m, 64'h0);
        chk("t9_ld",   any_ld_m, 64'h0);
        chk("t9_done", done_m,   64'h0);
        chk("t9_tap",  {49'd0, tap3}, 64'h0);

        // Reset in the middle of a SET
        issue(0, SET, 2'd1, 5'd20);
        repeat (3) begin @(posedge clk); #1; end
        chk("t10_mid_ce", {60'd0, ce4}, 64'h2);
        #2 rst = 1'b1;
        #1;
        chk("t10_rst_ce",   {60'd0, ce4}, 64'd0);
        chk("t10_rst_inc",  {60'd0, inc4}, 64'd0);
        chk("t10_rst_busy", {63'd0, busy4}, 64'd0);
        chk("t10_rst_tap",  {44'd0, tap4}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(0, SET, 2'd1, 5'd3);
        watch(2'd1, 64, 100, 0);
        chk("t10_ce",   ce_m,   64'h2A);
        chk("t10_done", done_m, 64'h40);
        chk("t10_tap",  {44'd0, tap4}, 64'h00060);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/idelay_tap_ctrl.md
# idelay_tap_ctrl

Parametrised tap sequencer for a bank of IDELAYE2 primitives in `VARIABLE` mode. It accepts tap commands over a valid/ready handshake and converts each one into correctly spaced single-cycle CE/INC/LD pulses on the addressed channel. It keeps a per-channel model of the current tap value, so callers can request absolute tap targets. It sits between input-capture calibration logic and the IDELAYE2 C/CE/INC/LD pins, clocked by the same `clk` that drives the delay elements' C input.

## Interface
- `CHANNELS`, 4: number of IDELAYE2 instances controlled (1..16).
- `CHAN_BITS`, 2: width of `req_chan`; must satisfy 2^CHAN_BITS >= CHANNELS.
- `INIT_TAP`, 0: value of IDELAY_VALUE on the delay elements. The tap model resets or loads to this value.
- `STEP_GAP`, 2: cycles from one CE pulse to the next (>= 1).

- `clk` in 1: single clock; also drives IDELAYE2 C.
- `rst` in 1: asynchronous, active-high reset.
- `rdy` in 1: IDELAYCTRL RDY.
- `req_valid` in 1: command valid.
- `req_ready` out 1: command accepted when `req_valid && req_ready` at a rising edge.
- `req_cmd` in 2: 00 SET (go to `req_tap`), 01 INC one, 10 DEC one, 11 LOAD (LD pulse, return to INIT_TAP).
- `req_chan` in CHAN_BITS: target channel.
- `req_tap` in 5: absolute target; used by SET only.
- `ce` out CHANNELS: per-channel IDELAYE2 CE.
- `inc` out CHANNELS: per-channel IDELAYE2 INC.
- `ld` out CHANNELS: per-channel IDELAYE2 LD.
- `tap_out` out 5*CHANNELS: packed tap model; channel k occupies bits [5k+4:5k].
- `busy` out 1: command in progress.
- `done` out 1: one-cycle pulse when a command completes.
- `err` out 1: one-cycle pulse when a command is rejected.

## Operation
- States:
  - IDLE: `req_ready = rdy`.
  - STEP: one CE cycle.
  - GAP: STEP_GAP-1 spacing cycles.
  - LOAD: one LD cycle.
  - FIN: `done` pulse, then back to IDLE.
- On accept, latch the channel and compute the step plan (`cur` is the channel's tap model):
  - SET: delta = (req_tap - cur) mod 32. If delta <= 16, step up delta times; otherwise step down 32-delta times. A tie at 16 steps up. A delta of 0 goes straight to FIN with no pulses.
  - INC/DEC: one step, wrapping 31->0 and 0->31, matching IDELAYE2 counter wrap.
  - LOAD: go to LOAD.
- STEP cycle:
  - `ce[ch]` = 1 and `inc[ch]` = direction; all other channels stay 0.
  - The tap model updates mod 32 at the same edge the pulse is registered.
- `inc[ch]` holds its direction only while `ce[ch]` is high; otherwise 0.
- While `rdy` is low outside IDLE, stay in GAP (pause). No CE or LD is issued until `rdy` returns. Remaining steps are preserved.
- A command with `req_chan >= CHANNELS` is still accepted. It produces `err` the cycle after acceptance, no pulses, no `done`, and no state change beyond the handshake.
- `busy` = 1 in every state except IDLE.
- No command queueing: `req_ready` is 0 while busy.

## Timing
- All outputs are registered.
- Reset values:
  - `ce`, `inc`, `ld`, `busy`, `done`, `err` = 0; `req_ready` = 0.
  - Every `tap_out` field = INIT_TAP.
  - State = IDLE.
- `req_ready` follows `rdy` from the first edge after reset is released.
- Accept at edge 0. For a plan of n >= 1 steps:
  - CE pulses occur in cycles 1, 1+G, ..., 1+(n-1)G, where G = STEP_GAP.
  - `done` is high in cycle 1+(n-1)G+1 (assuming `rdy` stays high).
  - `req_ready` is high again the cycle after `done`.
- n = 0: `done` in cycle 1.
- LOAD: `ld[ch]` in cycle 1, tap model = INIT_TAP from the end of cycle 1, `done` in cycle 2.
- Pauses from low `rdy` extend these figures by exactly the cycles `rdy` is low.
- Reset asserted mid-command:
  - All pulses drop asynchronously and the command is abandoned.
  - The tap models return to INIT_TAP. Hardware equivalence requires the caller to also issue LOAD on all channels after reset.
- Maximum SET duration is 16 steps, i.e. 1+15G+1 cycles.

## Test plan
- Reset, then SET ch1 to 5 with INIT_TAP=0 and G=2:
  - CE on ch1 at cycles 1,3,5,7,9 with `inc`=1; `done` at cycle 10.
  - `tap_out[9:5]` = 5; other channels stay at 0.
- Wrap/shortest path:
  - Ch0 at 2, SET 30: four DEC pulses, ending at 30.
  - INC from 31: ends at 0.
  - SET with delta exactly 16: 16 INC pulses.
- SET to the current value: no CE; `done` at cycle 1.
- LOAD on ch3 after stepping it to 12: one `ld[3]` pulse at cycle 1; tap model = INIT_TAP; `done` at cycle 2.
- `rdy` dropped for 5 cycles during a 4-step SET: no CE while low; total duration +5 cycles; final tap correct.
- Error and reset handling:
  - `req_chan` = 3 with CHANNELS = 3: `err` pulse; no `ce`/`ld`/`done`.
  - `rst` asserted mid-SET: outputs zero immediately, `tap_out` = INIT_TAP, next command accepted normally.
